// File: rtl/pet_ram_arbiter.sv
// Arbitrates the byte-wide DDR3 port between the ROM/TAP loader (writes, priority) and the tape player (reads).
// Optional PET_RAM_ARB_STATS_EN adds saturating write/read/timeout counters.
//
// state | meaning
// IDLE  | no transaction; pick loader first, then tape
// LD_WR | loader write: issue mem_req, wait for mem_ack or timeout
// TP_RD | tape read: issue mem_req, wait for mem_ack or timeout
module pet_ram_arbiter #(
  parameter int AW      = 25,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_active,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_wait,
  input  logic          tp_rd,
  input  logic [AW-1:0] tp_addr,
  output logic [7:0]    tp_data,
  output logic          tp_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack,
`ifdef PET_RAM_ARB_STATS_EN
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_rd,
  output logic [7:0]    stat_to,
`endif
  output logic          err
);

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LD_WR, TP_RD} state_t;

  state_t        state;
  logic          ld_pend;
  logic          tp_pend;
  logic [AW-1:0] ld_addr_q;
  logic [AW-1:0] tp_addr_q;
  logic [7:0]    ld_data_q;
  logic [15:0]   to_cnt;

  assign ld_wait = ld_wr | ld_pend | (state == LD_WR);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      ld_pend   <= 1'b0;
      tp_pend   <= 1'b0;
      ld_addr_q <= '0;
      tp_addr_q <= '0;
      ld_data_q <= 8'h00;
      to_cnt    <= '0;
      tp_data   <= 8'h00;
      tp_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 8'h00;
      err       <= 1'b0;
`ifdef PET_RAM_ARB_STATS_EN
      stat_wr   <= '0;
      stat_rd   <= '0;
      stat_to   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ld_pend)      state <= LD_WR;
          else if (tp_pend) state <= TP_RD;
        end
        LD_WR, TP_RD: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= (state == LD_WR);
            mem_addr <= (state == LD_WR) ? ld_addr_q : tp_addr_q;
            if (state == LD_WR) mem_din <= ld_data_q;
            to_cnt   <= TO_LOAD;
          end else if (mem_ack || to_cnt == 16'd0) begin
            // ack wins over a timeout landing in the same cycle
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == LD_WR) begin
              ld_pend <= 1'b0;
            end else begin
              tp_pend  <= 1'b0;
              tp_ready <= 1'b1;
              if (mem_ack) tp_data <= mem_dout;
            end
            if (!mem_ack) err <= 1'b1;
`ifdef PET_RAM_ARB_STATS_EN
            if (!mem_ack) begin
              if (stat_to != 8'hFF) stat_to <= stat_to + 8'd1;
            end else if (state == LD_WR) begin
              if (stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
            end else begin
              if (stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
            end
`endif
          end else begin
            to_cnt <= to_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // new strobes come last so they win over a same-cycle completion clear
      if (ld_wr) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end
      if (tp_rd && !ld_active) begin
        tp_pend   <= 1'b1;
        tp_addr_q <= tp_addr;
        tp_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pet_ram_arbiter.sv
// Directed bench for pet_ram_arbiter with TIMEOUT=8 and an inline memory responder.
module tb_pet_ram_arbiter;
  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ld_active = 1'b0, ld_wr = 1'b0;
  logic [AW-1:0] ld_addr = '0, tp_addr = '0;
  logic [7:0]    ld_data = 8'h00, mem_dout = 8'h00;
  logic          tp_rd = 1'b0, mem_ack = 1'b0;
  logic          ld_wait, tp_ready, mem_req, mem_we, err;
  logic [7:0]    tp_data, mem_din;
  logic [AW-1:0] mem_addr;
`ifdef PET_RAM_ARB_STATS_EN
  logic [15:0]   stat_wr, stat_rd;
  logic [7:0]    stat_to;
`endif

  int total = 0;
  int bad = 0;

  pet_ram_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_wait(ld_wait),
    .tp_rd(tp_rd), .tp_addr(tp_addr), .tp_data(tp_data), .tp_ready(tp_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack),
`ifdef PET_RAM_ARB_STATS_EN
    .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_to(stat_to),
`endif
    .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk_sys);
    while (!mem_req && n < 20) begin
      n++;
      cyc();
      @(negedge clk_sys);
    end
    chk(tag, {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    int lows, hi;

    // reset and idle
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_tp_data", {24'd0, tp_data}, 32'h00);
    chk("rst_mem", {mem_we, mem_din, 7'd0, mem_addr}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk_sys);
      chk("idle_flags", {28'd0, tp_ready, ld_wait, mem_req, err}, 32'b1000);
    end

    // loader write, ack 4 cycles after mem_req rises
    cyc();
    ld_active = 1'b1; ld_wr = 1'b1; ld_addr = 25'h10; ld_data = 8'hA5;
    @(negedge clk_sys);
    chk("wr_wait_strobe", {30'd0, ld_wait, mem_req}, 32'b10);
    cyc();
    ld_wr = 1'b0;
    @(negedge clk_sys);
    chk("wr_pend", {30'd0, ld_wait, mem_req}, 32'b10);
    cyc();
    @(negedge clk_sys);
    chk("wr_state", {30'd0, ld_wait, mem_req}, 32'b10);
    cyc();
    @(negedge clk_sys);
    chk("wr_req", {29'd0, ld_wait, mem_req, mem_we}, 32'b111);
    chk("wr_addr", 32'(mem_addr), 32'h10);
    chk("wr_din", {24'd0, mem_din}, 32'hA5);
    repeat (3) begin
      cyc();
      @(negedge clk_sys);
      chk("wr_hold", {30'd0, ld_wait, mem_req}, 32'b11);
    end
    cyc();
    mem_ack = 1'b1;
    @(negedge clk_sys);
    chk("wr_ack_cycle", {30'd0, ld_wait, mem_req}, 32'b11);
    cyc();
    mem_ack = 1'b0; ld_active = 1'b0;
    @(negedge clk_sys);
    chk("wr_done", {29'd0, ld_wait, mem_req, err}, 32'b000);

    // tape read, 2-cycle ack delay
    cyc();
    tp_rd = 1'b1; tp_addr = 25'h123;
    @(negedge clk_sys);
    chk("rd_ready_strobe", {31'd0, tp_ready}, 32'd1);
    cyc();
    tp_rd = 1'b0;
    @(negedge clk_sys);
    chk("rd_ready_fall", {30'd0, tp_ready, mem_req}, 32'b00);
    cyc();
    @(negedge clk_sys);
    chk("rd_state", {31'd0, mem_req}, 32'd0);
    cyc();
    @(negedge clk_sys);
    chk("rd_req", {30'd0, mem_req, mem_we}, 32'b10);
    chk("rd_addr", 32'(mem_addr), 32'h123);
    cyc();
    @(negedge clk_sys);
    chk("rd_hold", {30'd0, mem_req, tp_ready}, 32'b10);
    cyc();
    mem_ack = 1'b1; mem_dout = 8'h3C;
    @(negedge clk_sys);
    chk("rd_ack_cycle", {31'd0, tp_ready}, 32'd0);
    cyc();
    mem_ack = 1'b0; mem_dout = 8'h00;
    @(negedge clk_sys);
    chk("rd_done", {22'd0, tp_ready, mem_req, tp_data}, {22'd0, 2'b10, 8'h3C});

    // simultaneous write and read: write first
    cyc();
    ld_wr = 1'b1; ld_addr = 25'h5; ld_data = 8'h77;
    tp_rd = 1'b1; tp_addr = 25'h9;
    cyc();
    ld_wr = 1'b0; tp_rd = 1'b0;
    wait_req("sim_wr_req");
    chk("sim_first_wr", {mem_we, mem_din, 7'd0, mem_addr}, {1'b1, 8'h77, 7'd0, 25'h5});
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    lows = 0;
    @(negedge clk_sys);
    while (!mem_req && lows < 20) begin
      lows++;
      cyc();
      @(negedge clk_sys);
    end
    chk("sim_gap", 32'(lows), 32'd2);
    chk("sim_second_rd", {31'd0, mem_we}, 32'd0);
    chk("sim_rd_addr", 32'(mem_addr), 32'h9);
    mem_ack = 1'b1; mem_dout = 8'h5A;
    cyc();
    mem_ack = 1'b0; mem_dout = 8'h00;
    @(negedge clk_sys);
    chk("sim_rd_data", {23'd0, tp_ready, tp_data}, {23'd0, 1'b1, 8'h5A});

    // timeout on a read
    cyc();
    tp_rd = 1'b1; tp_addr = 25'h40;
    cyc();
    tp_rd = 1'b0;
    wait_req("to_req");
    hi = 0;
    while (mem_req && hi < 30) begin
      hi++;
      cyc();
      @(negedge clk_sys);
    end
    chk("to_req_len", 32'(hi), 32'd8);
    chk("to_flags", {23'd0, err, tp_ready, tp_data}, {23'd0, 2'b11, 8'h5A});
    mem_ack = 1'b1; mem_dout = 8'hEE;
    cyc();
    mem_ack = 1'b0; mem_dout = 8'h00;
    @(negedge clk_sys);
    chk("to_late_ack", {22'd0, mem_req, err, tp_ready, 1'b0, tp_data}, {22'd0, 4'b0110, 8'h5A});
    cyc();
    @(negedge clk_sys);
    chk("to_late_idle", {31'd0, mem_req}, 32'd0);

    // tape read ignored during download, then reset mid-write
    cyc();
    ld_active = 1'b1; tp_rd = 1'b1; tp_addr = 25'h77;
    cyc();
    tp_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("ign_rd", {30'd0, mem_req, tp_ready}, 32'b01);
      cyc();
    end
    ld_wr = 1'b1; ld_addr = 25'h20; ld_data = 8'h11;
    cyc();
    ld_wr = 1'b0;
    wait_req("rst_wr_req");
    chk("rst_wr_addr", {mem_we, 6'd0, mem_addr}, {1'b1, 6'd0, 25'h20});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_mid", {29'd0, mem_req, ld_wait, err}, 32'b000);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("rst_stray_ack", {29'd0, mem_req, ld_wait, tp_ready}, 32'b001);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=hang exp=finish");
    $fatal(1);
  end

endmodule
